// File: rtl/cmd_arbiter.sv
// cmd_arbiter: round-robin share of one 32-bit command channel.
// Grant is held until the response or a timeout code is returned.
module cmd_arbiter #(
  parameter int          N_REQ         = 4,
  parameter logic [15:0] TIMEOUT       = 16'd1000,
  parameter logic [31:0] TIMEOUT_CODE  = 32'hEEEE_0000,
  parameter logic [3:0]  NORESP_NIBBLE = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 cmd_out_valid,
  input  logic                 cmd_out_ready,
  output logic [31:0]          cmd_out,
  input  logic                 rsp_in_valid,
  output logic                 rsp_in_ready,
  input  logic [31:0]          rsp_in,
  output logic                 busy,
  output logic [15:0]          timeout_count
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_WAIT, S_RET
  } state_t;

  state_t state, state_n;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant;
  logic [IW-1:0] sel;
  logic          found;
  logic [31:0]   sel_data;
  logic [15:0]   timer;
  logic          noresp;
  logic          tmo_hit;
  int            j;

  assign noresp  = cmd_out[31:28] == NORESP_NIBBLE;
  assign tmo_hit = timer == TIMEOUT - 16'd1;

  // first valid requester after last_grant, with wrap-around
  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_valid[IW'(j)]) begin
        sel   = IW'(j);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      if (IW'(i) == sel) sel_data = req_data[32*i +: 32];
  end

  always_comb begin
    state_n      = state;
    req_ready    = '0;
    rsp_in_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        rsp_in_ready = 1'b1;
        if (found) begin
          req_ready[sel] = 1'b1;
          state_n        = S_SEND;
        end
      end
      S_SEND: begin
        if (cmd_out_ready)
          state_n = noresp ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        rsp_in_ready = 1'b1;
        if (rsp_in_valid || tmo_hit)
          state_n = S_RET;
      end
      S_RET: begin
        if (rsp_ready[grant])
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      last_grant    <= IW'(N_REQ - 1);
      grant         <= '0;
      cmd_out       <= '0;
      cmd_out_valid <= 1'b0;
      rsp_data      <= '0;
      rsp_valid     <= '0;
      busy          <= 1'b0;
      timer         <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_n;
      cmd_out_valid <= state_n == S_SEND;
      busy          <= state_n != S_IDLE;
      rsp_valid     <= '0;
      if (state_n == S_RET)
        rsp_valid[grant] <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            cmd_out    <= sel_data;
            grant      <= sel;
            last_grant <= sel;
          end
        end
        S_SEND: timer <= '0;
        S_WAIT: begin
          // a response in the last cycle beats the timeout
          if (rsp_in_valid) begin
            rsp_data <= rsp_in;
          end else if (tmo_hit) begin
            rsp_data <= TIMEOUT_CODE;
            if (timeout_count != 16'hFFFF)
              timeout_count <= timeout_count + 16'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
